// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI read transfer controller.
// Contents:
//   qspi_state_e  - transfer sequencer states
//   CMD_NIB       - opcode length in nibbles
//   RSIZE_MAX     - largest legal read length in bits
//   rsize_legal() - read-length legality check (non-zero, <= RSIZE_MAX, nibble aligned)
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DUMMY = 3'd3,
    DATA  = 3'd4,
    DONE  = 3'd5
  } qspi_state_e;

  localparam int CMD_NIB   = 2;
  localparam int RSIZE_MAX = 32;

  function automatic logic rsize_legal(input logic [5:0] rsize);
    return (rsize != 6'd0) && (rsize <= 6'(RSIZE_MAX)) && (rsize[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/qspi_phase_cnt.sv
// Phase length counter for the quad-SPI sequencer.
// Ports:
//   clk_i    in  core clock
//   rst_ni   in  synchronous active-low reset
//   load     in  load load_val this cycle (wins over decrement)
//   load_val in  phase length minus one
//   zero     out count has reached zero (last cycle of the phase)
module qspi_phase_cnt (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load,
  input  logic [5:0] load_val,
  output logic       zero
);

  logic [5:0] cnt_r;

  // Load, otherwise count down and park at zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_r <= 6'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != 6'd0) begin
      cnt_r <= cnt_r - 6'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 6'd0);

endmodule

// File: rtl/qspi_xfer_ctrl.sv
// Quad-SPI read transfer controller: sequences CMD, ADDR, optional DUMMY and
// DATA phases on four lanes, one transfer at a time.
// Ports:
//   clk_i, rst_ni          core clock, synchronous active-low reset
//   req_i, cmd_i, addr_i   request with opcode and address (MSB nibble first)
//   dummy_i, rsize_i       dummy cycle count, read length in bits
//   lsb_i                  shifter bit order, latched on accept
//   abort_i                kill the transfer in flight
//   ack_o, done_o, err_o   single-cycle host status pulses
//   cs_no, sclk_en_o       flash chip select (active low), SCLK gate enable
//   sdo_o, sdo_oe_o        lane data and lane output enables
//   rx_busy_o, rx_lsb_o, rx_rsize_o  receive shifter controls
// All outputs are registered; they are derived from the next state so they
// line up with the state they describe.
module qspi_xfer_ctrl
  import qspi_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int MAX_DUM = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [7:0]        cmd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        dummy_i,
  input  logic [5:0]        rsize_i,
  input  logic              lsb_i,
  input  logic              abort_i,
  output logic              ack_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cs_no,
  output logic              sclk_en_o,
  output logic [3:0]        sdo_o,
  output logic [3:0]        sdo_oe_o,
  output logic              rx_busy_o,
  output logic              rx_lsb_o,
  output logic [5:0]        rx_rsize_o
);

  localparam int SH_W     = 8 + ADDR_W;
  localparam int ADDR_NIB = ADDR_W / 4;

  qspi_state_e     state_r;
  qspi_state_e     state_nxt_s;
  logic [SH_W-1:0] shreg_r;
  logic [3:0]      dummy_r;
  logic            legal_s;
  logic            accept_s;
  logic            reject_s;
  logic            cnt_load_s;
  logic            cnt_zero_s;
  logic [6:0]      len_s;
  logic [5:0]      cnt_val_s;
  logic            nxt_drive_s;
  logic            nxt_active_s;

  assign legal_s  = rsize_legal(rsize_i) && (32'(dummy_i) <= 32'(MAX_DUM));
  assign accept_s = (state_r == IDLE) && req_i && legal_s;
  assign reject_s = (state_r == IDLE) && req_i && !legal_s;

  // Phase lengths are formed in 7 bits so the minus-one never wraps.
  assign cnt_val_s = 6'(len_s - 7'd1);

  assign nxt_drive_s  = (state_nxt_s == CMD) || (state_nxt_s == ADDR);
  assign nxt_active_s = nxt_drive_s || (state_nxt_s == DUMMY) || (state_nxt_s == DATA);

  qspi_phase_cnt u_phase_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // Next-state and phase counter load selection; abort wins outside IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_load_s  = 1'b0;
    len_s       = 7'd1;
    if (abort_i && (state_r != IDLE)) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_nxt_s = CMD;
            cnt_load_s  = 1'b1;
            len_s       = 7'(CMD_NIB);
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CMD: begin
          if (cnt_zero_s) begin
            state_nxt_s = ADDR;
            cnt_load_s  = 1'b1;
            len_s       = 7'(ADDR_NIB);
          end else begin
            state_nxt_s = CMD;
          end
        end
        ADDR: begin
          if (cnt_zero_s) begin
            cnt_load_s = 1'b1;
            if (dummy_r != 4'd0) begin
              state_nxt_s = DUMMY;
              len_s       = {3'b000, dummy_r};
            end else begin
              state_nxt_s = DATA;
              len_s       = {3'b000, rx_rsize_o[5:2]} + 7'd1;
            end
          end else begin
            state_nxt_s = ADDR;
          end
        end
        DUMMY: begin
          if (cnt_zero_s) begin
            state_nxt_s = DATA;
            cnt_load_s  = 1'b1;
            len_s       = {3'b000, rx_rsize_o[5:2]} + 7'd1;
          end else begin
            state_nxt_s = DUMMY;
          end
        end
        DATA: begin
          if (cnt_zero_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = DATA;
          end
        end
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register, latched request fields, nibble shifter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      dummy_r    <= 4'd0;
      rx_rsize_o <= 6'd0;
      rx_lsb_o   <= 1'b0;
      ack_o      <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      cs_no      <= 1'b1;
      sclk_en_o  <= 1'b0;
      sdo_o      <= 4'h0;
      sdo_oe_o   <= 4'h0;
      rx_busy_o  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ack_o     <= accept_s;
      err_o     <= reject_s;
      done_o    <= (state_nxt_s == DONE);
      cs_no     <= !nxt_active_s;
      sdo_oe_o  <= nxt_drive_s ? 4'hF : 4'h0;
      rx_busy_o <= (state_nxt_s == DATA);
      // The first DATA cycle primes the shifter index and gets no SCLK edge.
      sclk_en_o <= nxt_drive_s || (state_nxt_s == DUMMY) ||
                   ((state_nxt_s == DATA) && (state_r == DATA));
      if (accept_s) begin
        sdo_o      <= cmd_i[7:4];
        shreg_r    <= {cmd_i[3:0], addr_i, 4'h0};
        dummy_r    <= dummy_i;
        rx_rsize_o <= rsize_i;
        rx_lsb_o   <= lsb_i;
      end else if (nxt_drive_s) begin
        sdo_o   <= shreg_r[SH_W-1 -: 4];
        shreg_r <= {shreg_r[SH_W-5:0], 4'h0};
      end else begin
        sdo_o <= 4'h0;
      end
    end
  end

endmodule
